// File: rtl/stream_demux_reg.sv
// Registered stream demultiplexer: routes each input beat to one of N_OUP
// one-entry output registers; beats with an out-of-range select are dropped and counted.
module stream_demux_reg #(
    parameter type DATA_T    = logic,
    parameter int  N_OUP     = 2,
    parameter int  CNT_W     = 16,
    parameter int  LOG_N_OUP = (N_OUP > 1) ? $clog2(N_OUP) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  DATA_T                 inp_data_i,
    input  logic [LOG_N_OUP-1:0]  inp_sel_i,
    input  logic                  inp_valid_i,
    output logic                  inp_ready_o,
    output DATA_T [N_OUP-1:0]     oup_data_o,
    output logic  [N_OUP-1:0]     oup_valid_o,
    input  logic  [N_OUP-1:0]     oup_ready_i,
    output logic                  drop_o,
    output logic  [CNT_W-1:0]     drop_cnt_o
);

    localparam logic [LOG_N_OUP:0] N_OUP_W = (LOG_N_OUP + 1)'(N_OUP);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    DATA_T [N_OUP-1:0]    data_p1;
    logic  [N_OUP-1:0]    vld_p1;
    logic                 drop_p1;
    logic  [CNT_W-1:0]    cnt_p1;

    logic [LOG_N_OUP-1:0] sel_idx_p0;
    logic                 sel_ok_p0;
    logic                 hs_p0;

    // Stage p0: select decode and combinational ready (ready follows oup_ready_i directly)
    assign sel_idx_p0  = (N_OUP == 1) ? '0 : inp_sel_i;
    assign sel_ok_p0   = (N_OUP == 1) || ({1'b0, inp_sel_i} < N_OUP_W);
    assign inp_ready_o = rst_ni &
                         (sel_ok_p0 ? (~vld_p1[sel_idx_p0] | oup_ready_i[sel_idx_p0]) : 1'b1);
    assign hs_p0       = inp_valid_i & inp_ready_o;

    // Stage p1: per-output registers; a load on k takes priority over draining k
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_p1 <= '0;
            vld_p1  <= '0;
            drop_p1 <= 1'b0;
            cnt_p1  <= '0;
        end else begin
            drop_p1 <= hs_p0 & ~sel_ok_p0;
            if (hs_p0 && !sel_ok_p0) begin
                cnt_p1 <= sat_inc(cnt_p1);
            end
            for (int k = 0; k < N_OUP; k++) begin
                if (hs_p0 && sel_ok_p0 && (sel_idx_p0 == LOG_N_OUP'(k))) begin
                    vld_p1[k]  <= 1'b1;
                    data_p1[k] <= inp_data_i;
                end else if (vld_p1[k] && oup_ready_i[k]) begin
                    vld_p1[k]  <= 1'b0;
                end
            end
        end
    end

    assign oup_data_o  = data_p1;
    assign oup_valid_o = vld_p1;
    assign drop_o      = drop_p1;
    assign drop_cnt_o  = cnt_p1;

`ifndef SYNTHESIS
    if (N_OUP < 1) begin : g_bad_n_oup
        $error("stream_demux_reg: N_OUP must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("stream_demux_reg: CNT_W must be >= 1");
    end

    a_inp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (inp_valid_i && !inp_ready_o) |=>
            (!inp_valid_i || ($stable(inp_data_i) && $stable(inp_sel_i))));

    for (genvar k = 0; k < N_OUP; k++) begin : g_oup_chk
        a_oup_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (oup_valid_o[k] && !oup_ready_i[k]) |=>
                (oup_valid_o[k] && $stable(oup_data_o[k])));
    end
`endif

endmodule

// File: tb/tb_stream_demux_reg.sv
// Directed bench for stream_demux_reg: a vector table on a 4-output instance plus
// hand-written sequences for drop saturation and mid-operation reset on 3-output instances.
module tb_stream_demux_reg;

    typedef logic [7:0] byte_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: N_OUP=4, default counter
    byte_t            a_data;
    logic [1:0]       a_sel;
    logic             a_valid, a_ready;
    byte_t [3:0]      a_odata;
    logic  [3:0]      a_ovalid, a_oready;
    logic             a_drop;
    logic [15:0]      a_cnt;

    // Instance B: N_OUP=3, CNT_W=2 (saturation)
    byte_t            b_data;
    logic [1:0]       b_sel;
    logic             b_valid, b_ready;
    byte_t [2:0]      b_odata;
    logic  [2:0]      b_ovalid, b_oready;
    logic             b_drop;
    logic [1:0]       b_cnt;

    // Instance C: N_OUP=3, CNT_W=8 (mid-operation reset)
    logic             c_rst_n;
    byte_t            c_data;
    logic [1:0]       c_sel;
    logic             c_valid, c_ready;
    byte_t [2:0]      c_odata;
    logic  [2:0]      c_ovalid, c_oready;
    logic             c_drop;
    logic [7:0]       c_cnt;

    stream_demux_reg #(.DATA_T(byte_t), .N_OUP(4), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .inp_data_i(a_data), .inp_sel_i(a_sel),
        .inp_valid_i(a_valid), .inp_ready_o(a_ready), .oup_data_o(a_odata),
        .oup_valid_o(a_ovalid), .oup_ready_i(a_oready), .drop_o(a_drop), .drop_cnt_o(a_cnt));

    stream_demux_reg #(.DATA_T(byte_t), .N_OUP(3), .CNT_W(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .inp_data_i(b_data), .inp_sel_i(b_sel),
        .inp_valid_i(b_valid), .inp_ready_o(b_ready), .oup_data_o(b_odata),
        .oup_valid_o(b_ovalid), .oup_ready_i(b_oready), .drop_o(b_drop), .drop_cnt_o(b_cnt));

    stream_demux_reg #(.DATA_T(byte_t), .N_OUP(3), .CNT_W(8)) u_c (
        .clk_i(clk), .rst_ni(c_rst_n), .inp_data_i(c_data), .inp_sel_i(c_sel),
        .inp_valid_i(c_valid), .inp_ready_o(c_ready), .oup_data_o(c_odata),
        .oup_valid_o(c_ovalid), .oup_ready_i(c_oready), .drop_o(c_drop), .drop_cnt_o(c_cnt));

    typedef struct packed {
        logic       v;
        logic [1:0] sel;
        byte_t      d;
        logic [3:0] rdy;
        logic       e_rdy;
        logic [3:0] e_vld;
        logic [1:0] chk;
        byte_t      e_dat;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge and settle just past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        c_rst_n = 1'b0;
        a_valid = 0; a_sel = 0; a_data = 0; a_oready = '0;
        b_valid = 0; b_sel = 0; b_data = 0; b_oready = '0;
        c_valid = 0; c_sel = 0; c_data = 0; c_oready = '0;

        // route, back-pressure isolation, throughput, simultaneous drain/load
        vq.push_back('{1'b1, 2'd2, 8'hA5, 4'b1111, 1'b1, 4'b0100, 2'd2, 8'hA5});
        vq.push_back('{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd2, 8'h00});
        vq.push_back('{1'b1, 2'd1, 8'h11, 4'b1101, 1'b1, 4'b0010, 2'd1, 8'h11});
        vq.push_back('{1'b1, 2'd1, 8'h22, 4'b1101, 1'b0, 4'b0010, 2'd1, 8'h11});
        vq.push_back('{1'b1, 2'd1, 8'h22, 4'b1101, 1'b0, 4'b0010, 2'd1, 8'h11});
        vq.push_back('{1'b0, 2'd1, 8'h22, 4'b1101, 1'b0, 4'b0010, 2'd1, 8'h11});
        vq.push_back('{1'b1, 2'd3, 8'h33, 4'b1101, 1'b1, 4'b1010, 2'd3, 8'h33});
        vq.push_back('{1'b1, 2'd1, 8'h22, 4'b1111, 1'b1, 4'b0010, 2'd1, 8'h22});
        vq.push_back('{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd0, 8'h00});
        for (int i = 0; i < 8; i++)
            vq.push_back('{1'b1, 2'd0, byte_t'(i), 4'b1111, 1'b1, 4'b0001, 2'd0, byte_t'(i)});
        vq.push_back('{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd0, 8'h00});
        vq.push_back('{1'b1, 2'd1, 8'h44, 4'b0000, 1'b1, 4'b0010, 2'd1, 8'h44});
        vq.push_back('{1'b0, 2'd1, 8'h44, 4'b0000, 1'b0, 4'b0010, 2'd1, 8'h44});
        vq.push_back('{1'b1, 2'd1, 8'h55, 4'b0010, 1'b1, 4'b0010, 2'd1, 8'h55});
        vq.push_back('{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd0, 8'h00});

        tick();
        tick();
        check("rst_ready_a", 32'(a_ready), 32'd0);
        check("rst_valid_a", 32'(a_ovalid), 32'd0);
        check("rst_data_a", a_odata, 32'd0);
        check("rst_drop_a", 32'(a_drop), 32'd0);
        check("rst_cnt_a", 32'(a_cnt), 32'd0);
        rst_n   = 1'b1;
        c_rst_n = 1'b1;

        foreach (vq[i]) begin
            a_valid = vq[i].v; a_sel = vq[i].sel; a_data = vq[i].d; a_oready = vq[i].rdy;
            #1;
            check($sformatf("vec%0d_inp_ready", i), 32'(a_ready), 32'(vq[i].e_rdy));
            tick();
            check($sformatf("vec%0d_oup_valid", i), 32'(a_ovalid), 32'(vq[i].e_vld));
            if (vq[i].e_vld[vq[i].chk])
                check($sformatf("vec%0d_oup_data", i), 32'(a_odata[vq[i].chk]), 32'(vq[i].e_dat));
        end
        a_valid = 0;
        check("a_no_drop", 32'(a_cnt), 32'd0);

        // Illegal select on B: five drops, counter saturates at 3
        begin
            int pulses = 0;
            b_oready = 3'b111;
            for (int i = 0; i < 5; i++) begin
                b_valid = 1; b_sel = 2'd3; b_data = byte_t'(8'hE0 + i);
                #1;
                check($sformatf("drop%0d_ready", i), 32'(b_ready), 32'd1);
                tick();
                if (b_drop) pulses++;
                check($sformatf("drop%0d_no_valid", i), 32'(b_ovalid), 32'd0);
                check($sformatf("drop%0d_cnt", i), 32'(b_cnt), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
            end
            b_valid = 0;
            tick();
            check("drop_pulse_count", 32'(pulses), 32'd5);
            check("drop_after_idle", 32'(b_drop), 32'd0);
            check("drop_cnt_sat", 32'(b_cnt), 32'd3);
        end

        // Mid-operation reset on C
        c_oready = 3'b000;
        c_valid = 1; c_sel = 2'd0; c_data = 8'h61;
        tick();
        c_sel = 2'd2; c_data = 8'h62;
        tick();
        for (int i = 0; i < 5; i++) begin
            c_sel = 2'd3; c_data = byte_t'(8'hD0 + i);
            tick();
        end
        c_valid = 0;
        check("pre_rst_valid", 32'(c_ovalid), 32'b101);
        check("pre_rst_data0", 32'(c_odata[0]), 32'h61);
        check("pre_rst_data2", 32'(c_odata[2]), 32'h62);
        check("pre_rst_cnt", 32'(c_cnt), 32'd5);
        check("pre_rst_drop", 32'(c_drop), 32'd1);
        c_rst_n = 1'b0;
        c_valid = 1; c_sel = 2'd1; c_data = 8'h77;
        #1;
        check("in_rst_ready", 32'(c_ready), 32'd0);
        tick();
        check("post_rst_valid", 32'(c_ovalid), 32'd0);
        check("post_rst_cnt", 32'(c_cnt), 32'd0);
        check("post_rst_drop", 32'(c_drop), 32'd0);
        c_rst_n = 1'b1;
        c_oready = 3'b111;
        #1;
        check("after_rst_ready", 32'(c_ready), 32'd1);
        tick();
        c_valid = 0;
        check("after_rst_valid", 32'(c_ovalid), 32'b010);
        check("after_rst_data", 32'(c_odata[1]), 32'h77);
        tick();
        check("after_rst_drain", 32'(c_ovalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
